ring_sequence_checker: RTL
==========================

Name: ring_sequence_checker

Overview:
- Receive-side companion to the team's one-hot ring counter.
- Samples a WIDTH-bit ring code, decodes it to a binary index and checks that each sample is legal one-hot.
- Checks that each step is the expected rotate-left of the previous sample.
- Runs a HUNT/SYNC/LOCKED state machine and reports lock status, step-error pulses and a saturating error count; sits between any ring-counter source and the control logic that consumes its position.

Parameters:
WIDTH, 4, ring width in bits (≥2); legal codes are one-hot; index width IW = $clog2(WIDTH)
LOCK_COUNT, 4, consecutive in-sequence samples (counting the first) required to enter LOCKED (≥1)
ERR_W, 8, width of the error counter

Ports:
Clock  input  1  rising-edge clock, single clock domain
Reset_n  input  1  synchronous, active-low reset
Enable  input  1  sample qualifier; Ring_in is evaluated only when high
Ring_in  input  WIDTH  ring code under check
Index  output  IW  binary position of the set bit of the last legal sample
Onehot_ok  output  1  last sampled code was exactly one-hot
Locked  output  1  state machine is in LOCKED
Step_err  output  1  one-cycle pulse: sequence broken while LOCKED
Err_count  output  ERR_W  saturating count of Step_err pulses

Behaviour:
- Interface (decided): one clock, Clock; reset Reset_n is synchronous and active-low.
- Reset (Reset_n=0 at a rising edge):
  - Outputs: Index=0, Onehot_ok=0, Locked=0, Step_err=0, Err_count=0.
  - Internals: state=HUNT, prev=0, good_cnt=0.
  - Reset has priority over Enable, including mid-lock.
- All outputs are registered. Latency is 1 cycle: a sample taken at edge N is reflected after edge N.
- Enable=0: all state and outputs hold, except Step_err, which is 0.
- Legal code: exactly one bit set. All-zero and multi-bit codes are illegal.
- Expected code: rotl(prev) = {prev[WIDTH-2:0], prev[WIDTH-1]}. The MSB wraps to the LSB (1000 -> 0001 for WIDTH=4).
- Onehot_ok is updated on every enabled sample.
- Index updates only on legal samples; on illegal samples it holds.
- prev updates on every legal sample.
- HUNT:
  - Legal sample: prev<=code, good_cnt<=1. If LOCK_COUNT==1 go to LOCKED, otherwise go to SYNC.
  - Illegal sample: stay in HUNT.
- SYNC:
  - code==rotl(prev): good_cnt++; go to LOCKED when good_cnt+1 == LOCK_COUNT.
  - Legal but unexpected: good_cnt<=1, stay in SYNC (restart from this code).
  - Illegal: go to HUNT, good_cnt<=0.
  - No Step_err in SYNC.
- LOCKED:
  - code==rotl(prev): stay.
  - Any other code (illegal, repeated or skipped): Step_err=1 for one cycle, Err_count+1 saturating at 2^ERR_W-1, go to HUNT, good_cnt<=0.
  - Locked is deasserted in the same registered update as the Step_err pulse.
- Locked=1 exactly while state==LOCKED.
- good_cnt is sized to hold LOCK_COUNT and never exceeds it.
- Err_count is cleared only by reset; it does not wrap.
- A repeated identical code (a stalled counter with Enable=1) counts as an unexpected step.

Test Plan:
- Reset then Enable=1 with 0001,0010,0100,1000: Locked rises after the 4th edge; Index=0,1,2,3; Onehot_ok=1; Step_err never asserts.
- Locked, then feed 0100 after 0001: one Step_err pulse, Err_count=1, Locked=0 on the same edge; next legal 0100 restarts SYNC.
- Locked, then feed 0110: Onehot_ok=0, Index holds 0, Step_err=1, state HUNT; then 0000 x3: stays in HUNT, no further Step_err.
- Wrap check: lock on 0100,1000,0001,0010,0100: stays locked across 1000->0001, Err_count=0.
- Enable=0 for 10 cycles with Ring_in toggling garbage while locked: all outputs hold and Locked stays 1. Then resume with the correct next code: still locked.
- Reset_n=0 for one cycle while LOCKED with Err_count=5: next cycle all outputs are 0 and state is HUNT. With ERR_W=2, forcing 5 lock/break cycles leaves Err_count at 3.

Source files
------------

// File: rtl/ring_sequence_checker.sv
// Receive-side checker for a one-hot ring counter: decodes the sampled
// ring code to a binary index, checks one-hot legality and rotate-left
// stepping, and tracks lock through a HUNT/SYNC/LOCKED state machine.
module ring_sequence_checker #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     Enable,
  input  logic [WIDTH-1:0]         Ring_in,
  output logic [$clog2(WIDTH)-1:0] Index,
  output logic                     Onehot_ok,
  output logic                     Locked,
  output logic                     Step_err,
  output logic [ERR_W-1:0]         Err_count
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CW-1:0]    good_q, good_d;
  logic [IW-1:0]    index_q, index_d;
  logic             onehot_q, onehot_d;
  logic             step_err_q, step_err_d;
  logic [ERR_W-1:0] err_q, err_d;

  int unsigned      ones;
  logic [IW-1:0]    code_idx;
  logic             legal;
  logic [WIDTH-1:0] expected;
  logic             in_seq;

  // Decode the incoming code: population count, set-bit position, and
  // whether it is the rotate-left successor of the last legal sample.
  always_comb begin
    ones     = 0;
    code_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (Ring_in[i]) begin
        ones     = ones + 1;
        code_idx = IW'(i);
      end
    end
    legal    = (ones == 1);
    expected = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    // prev is all-zero after reset, so its rotation can never match a legal code
    in_seq   = legal && (Ring_in == expected);
  end

  // Next-state and registered-output logic; everything holds while Enable is low
  // except the Step_err pulse, which defaults to zero every cycle.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    good_d     = good_q;
    index_d    = index_q;
    onehot_d   = onehot_q;
    step_err_d = 1'b0;
    err_d      = err_q;

    if (Enable) begin
      onehot_d = legal;
      if (legal) begin
        index_d = code_idx;
        prev_d  = Ring_in;
      end

      unique case (state_q)
        HUNT: begin
          if (legal) begin
            good_d  = CW'(1);
            state_d = (LOCK_COUNT == 1) ? LOCKED : SYNC;
          end
        end

        SYNC: begin
          if (in_seq) begin
            good_d = good_q + CW'(1);
            if (32'(good_q) + 32'd1 == LOCK_COUNT) begin
              state_d = LOCKED;
            end
          end else if (legal) begin
            // Restart the run from this code rather than dropping to HUNT
            good_d = CW'(1);
          end else begin
            good_d  = '0;
            state_d = HUNT;
          end
        end

        LOCKED: begin
          if (!in_seq) begin
            step_err_d = 1'b1;
            if (err_q != '1) begin
              err_d = err_q + ERR_W'(1);
            end
            good_d  = '0;
            state_d = HUNT;
          end
        end

        default: begin
          good_d  = '0;
          state_d = HUNT;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q    <= HUNT;
      prev_q     <= '0;
      good_q     <= '0;
      index_q    <= '0;
      onehot_q   <= 1'b0;
      step_err_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      good_q     <= good_d;
      index_q    <= index_d;
      onehot_q   <= onehot_d;
      step_err_q <= step_err_d;
      err_q      <= err_d;
    end
  end

  assign Index     = index_q;
  assign Onehot_ok = onehot_q;
  assign Locked    = (state_q == LOCKED);
  assign Step_err  = step_err_q;
  assign Err_count = err_q;

endmodule
